// File: rtl/fetch_unit_if.sv
// fetch_unit_if: sequencer/loader-side signal bundle for fetch_unit.
// The master drives fetch, branch and program-load requests.
// The slave returns the fetched instruction, its PC, a valid pulse and the halt flag.
interface fetch_unit_if #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 16
);
    logic               I_enfetch;
    logic               I_branch;
    logic [ADDR_W-1:0]  I_branch_target;
    logic               I_ld_en;
    logic [ADDR_W-1:0]  I_ld_addr;
    logic [INSTR_W-1:0] I_ld_data;
    logic [INSTR_W-1:0] O_instr;
    logic [ADDR_W-1:0]  O_pc;
    logic               O_valid;
    logic               O_halt;

    modport master (
        output I_enfetch, I_branch, I_branch_target,
        output I_ld_en, I_ld_addr, I_ld_data,
        input  O_instr, O_pc, O_valid, O_halt
    );

    modport slave (
        input  I_enfetch, I_branch, I_branch_target,
        input  I_ld_en, I_ld_addr, I_ld_data,
        output O_instr, O_pc, O_valid, O_halt
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC register plus a 2**ADDR_W x INSTR_W instruction memory.
// A fetch registers mem[PC] and PC, then advances PC, with a latency of one cycle.
// The memory can be written at any time through the load port.
// A fetched opcode of 4'hF stops fetching until reset.
// Optional macro FETCH_PC_WRAP_EN: when it is defined, a fetch at the last address wraps PC to 0.
// When it is left undefined, the fetch at the last address completes and then the unit halts.
module fetch_unit #(
    parameter int ADDR_W  = 6,
    parameter int INSTR_W = 16
) (
    input  logic          I_clk,
    input  logic          I_reset,
    fetch_unit_if.slave   bus
);
    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PC = '1;
    localparam logic [3:0]      OP_HALT = 4'hF;

    typedef enum logic {
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t              state_q;
    logic [INSTR_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_next;
    logic [ADDR_W-1:0]   pc_out_q;
    logic [INSTR_W-1:0]  instr_q;
    logic                valid_q;
    logic                fetch_go;
    logic [INSTR_W-1:0]  rd_word;
    logic                op_halt;
    logic                end_halt;
    logic                stop_now;

    assign fetch_go = bus.I_enfetch && (state_q == ST_RUN);
    assign rd_word  = mem[pc_q];
    assign op_halt  = (rd_word[INSTR_W-1 -: 4] == OP_HALT);

`ifdef FETCH_PC_WRAP_EN
    assign end_halt = 1'b0;
`else
    assign end_halt = (pc_q == LAST_PC);
`endif

    assign stop_now = fetch_go && (op_halt || end_halt);

    // Program load port; the memory is never cleared, and a fetch on the same edge sees the old word.
    always_ff @(posedge I_clk) begin
        if (bus.I_ld_en) begin
            mem[bus.I_ld_addr] <= bus.I_ld_data;
        end
    end

    // Next PC: a branch beats the increment, a stopping fetch freezes PC, and a halted unit ignores everything.
    always_comb begin
        pc_next = pc_q;
        if (state_q == ST_RUN) begin
            if (stop_now) begin
                pc_next = pc_q;
            end else if (bus.I_branch) begin
                pc_next = bus.I_branch_target;
            end else if (fetch_go) begin
                pc_next = pc_q + ADDR_W'(1);
            end
        end
    end

    // Run/halt state, PC and the registered fetch outputs.
    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            state_q  <= ST_RUN;
            pc_q     <= '0;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            pc_q    <= pc_next;
            if (fetch_go) begin
                instr_q  <= rd_word;
                pc_out_q <= pc_q;
                valid_q  <= 1'b1;
            end
            if (stop_now) begin
                state_q <= ST_HALTED;
            end
        end
    end

    assign bus.O_instr = instr_q;
    assign bus.O_pc    = pc_out_q;
    assign bus.O_valid = valid_q;
    assign bus.O_halt  = (state_q == ST_HALTED);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit.
// The stimulus process runs a memory/PC reference model and queues each expected fetch.
// An independent monitor pops and compares the queue whenever O_valid is seen.
module tb_fetch_unit;
    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 64;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic               halt;
    } exp_t;

    logic I_clk;
    logic I_reset;
    int   tests;
    int   fails;

    exp_t               sb[$];
    logic [INSTR_W-1:0] m_mem [DEPTH];
    int                 m_pc;
    bit                 m_halt;

    fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .I_clk   (I_clk),
        .I_reset (I_reset),
        .bus     (bus)
    );

    // Free-running clock, 10 ns period.
    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour of one clock edge, written directly from the fetch rules.
    task automatic model_edge(input bit en, input bit br, input int tgt,
                              input bit ld, input int la, input logic [INSTR_W-1:0] ldd);
        exp_t e;
        if (!m_halt && en) begin
            e.instr = m_mem[m_pc];
            e.pc    = ADDR_W'(m_pc);
            if (e.instr[15:12] == 4'hF) begin
                m_halt = 1;
            end else if (m_pc == DEPTH - 1) begin
`ifdef FETCH_PC_WRAP_EN
                m_pc = br ? tgt : 0;
`else
                m_halt = 1;
`endif
            end else begin
                m_pc = br ? tgt : m_pc + 1;
            end
            e.halt = m_halt;
            sb.push_back(e);
        end else if (!m_halt && br) begin
            m_pc = tgt;
        end
        if (ld) m_mem[la] = ldd;
    endtask

    // Drive one cycle of inputs from a falling edge, then clear them on the next falling edge.
    task automatic apply_stimulus(input bit en, input bit br, input int tgt,
                                  input bit ld, input int la, input logic [INSTR_W-1:0] ldd);
        bus.I_enfetch       = en;
        bus.I_branch        = br;
        bus.I_branch_target = ADDR_W'(tgt);
        bus.I_ld_en         = ld;
        bus.I_ld_addr       = ADDR_W'(la);
        bus.I_ld_data       = ldd;
        @(posedge I_clk);
        model_edge(en, br, tgt, ld, la, ldd);
        @(negedge I_clk);
        bus.I_enfetch = 1'b0;
        bus.I_branch  = 1'b0;
        bus.I_ld_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_instr"}, 32'(bus.O_instr), 32'h0);
        check_output({tag, "_pc"},    32'(bus.O_pc),    32'h0);
        check_output({tag, "_valid"}, 32'(bus.O_valid), 32'h0);
        check_output({tag, "_halt"},  32'(bus.O_halt),  32'h0);
    endtask

    // Reset asserted between edges; the outputs must clear before any clock edge arrives.
    task automatic async_reset(input string tag);
        #2;
        I_reset = 1'b1;
        #1;
        check_reset_outputs(tag);
        m_pc   = 0;
        m_halt = 0;
        @(negedge I_clk);
        I_reset = 1'b0;
    endtask

    // Monitor: every O_valid pulse must match the oldest queued fetch.
    always @(posedge I_clk) begin
        #1;
        if (bus.O_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check_output("unexpected_valid", 32'(bus.O_pc), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_output("fetch_instr", 32'(bus.O_instr), 32'(e.instr));
                check_output("fetch_pc",    32'(bus.O_pc),    32'(e.pc));
                check_output("fetch_halt",  32'(bus.O_halt),  32'(e.halt));
            end
        end
    end

    initial begin
        logic [INSTR_W-1:0] d;
        logic [31:0]        r;
        tests = 0;
        fails = 0;
        m_pc = 0;
        m_halt = 0;
        bus.I_enfetch = 1'b0;
        bus.I_branch = 1'b0;
        bus.I_branch_target = '0;
        bus.I_ld_en = 1'b0;
        bus.I_ld_addr = '0;
        bus.I_ld_data = '0;
        I_reset = 1'b1;
        #1;
        check_reset_outputs("por");
        @(negedge I_clk);
        @(negedge I_clk);
        I_reset = 1'b0;

        // Program image: 1111/2222/3333 at 0..2, then i*0x0101 elsewhere (0707 at address 7).
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 3) d = 16'h1111 * 16'(i + 1);
            else       d = 16'h0101 * 16'(i);
            apply_stimulus(0, 0, 0, 1, i, d);
        end

        // Three fetches spaced six cycles apart.
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 0, 0, 0, 0, 16'h0);
            idle(5);
        end

        // Branch on its own, then a branch that coincides with a fetch at PC=5.
        apply_stimulus(0, 1, 40, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);
        apply_stimulus(0, 1, 5, 0, 0, 16'h0);
        apply_stimulus(1, 1, 40, 0, 0, 16'h0);
        idle(1);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);

        // Same-edge load and fetch at 7 reads the old word; a refetch reads the new one.
        apply_stimulus(0, 1, 7, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 1, 7, 16'hABCD);
        apply_stimulus(0, 1, 7, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);

        // Randomized mix of fetches, branches and loads.
        for (int i = 0; i < 200; i++) begin
            r = $urandom;
            d = 16'($urandom);
            if (d[15:12] == 4'hF) d[15] = 1'b0;
            apply_stimulus(r[0], r[3:1] == 3'd0, $urandom_range(0, 55),
                           r[5:4] == 2'd0, $urandom_range(0, DEPTH - 1), d);
        end

        // Asynchronous reset while a valid pulse is on the outputs; memory must survive it.
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);
        async_reset("mid_reset");
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);

        // Halt opcode at 3; later fetches and branches are ignored, loads still land.
        apply_stimulus(0, 0, 0, 1, 3, 16'hF000);
        apply_stimulus(0, 1, 3, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);
        apply_stimulus(1, 1, 20, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 1, 10, 16'h1234);
        apply_stimulus(0, 1, 30, 0, 0, 16'h0);
        check_output("halt_sticky",  32'(bus.O_halt),  32'h1);
        check_output("halt_pc_held", 32'(bus.O_pc),    32'h3);
        check_output("halt_instr",   32'(bus.O_instr), 32'hF000);
        async_reset("halt_reset");

        // Loaded-while-halted word at 10 must be visible after reset.
        apply_stimulus(0, 1, 10, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);

        // End of memory: branch to 63 and fetch, then try once more.
        apply_stimulus(0, 1, 63, 0, 0, 16'h0);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);
`ifdef FETCH_PC_WRAP_EN
        check_output("end_no_halt", 32'(bus.O_halt), 32'h0);
`else
        check_output("end_halt",    32'(bus.O_halt), 32'h1);
`endif
        check_output("end_pc", 32'(bus.O_pc), 32'd63);
        apply_stimulus(1, 0, 0, 0, 0, 16'h0);
        idle(3);
        check_output("scoreboard_drain", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
